exe_mul_sequencer: RTL
======================

EXE_MUL_SEQUENCER -- requirements
Module: exe_mul_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; iteration count equals WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 flush  input  1  abort the in-flight operation (branch taken or pipeline flush).
REQ-006 Val_1  input  WIDTH  multiplicand (Rm operand).
REQ-007 Val_2  input  WIDTH  multiplier (Rs operand).
REQ-008 Acc  input  WIDTH  accumulate operand (Rn); used only when MUL_ACC_EN is defined.
REQ-009 acc_en  input  1  select MLA over MUL; used only when MUL_ACC_EN is defined.
REQ-010 S  input  1  update-flags request, captured with start.
REQ-011 Dest  input  4  destination register, captured with start.
REQ-012 busy  output  1  pipeline freeze request; high in BUSY.
REQ-013 done  output  1  one-cycle result-valid pulse.
REQ-014 Mul_Res  output  WIDTH  low WIDTH bits of product (plus Acc for MLA).
REQ-015 Dest_out  output  4  captured Dest, held stable while done is high.
REQ-016 S_out  output  1  captured S, qualified by done.
REQ-017 Status_Bits  output  4  {N,Z,C,V}: N = Mul_Res[WIDTH-1], Z = (Mul_Res == 0), C = 0, V = 0.

Function
REQ-018 FSM states: IDLE, BUSY, DONE.
- IDLE->BUSY on start=1.
- BUSY->DONE when the iteration counter reaches WIDTH-1.
- DONE->IDLE unconditionally.
REQ-019 On IDLE with start=1, capture Val_1 into the multiplicand register, Val_2 into the multiplier register, Dest and S; clear the accumulator (or load Acc, see REQ-030); clear the counter.
REQ-020 Each BUSY cycle:
- If multiplier[0]=1, accumulator += multiplicand, modulo 2^WIDTH.
- Multiplicand shifts left by 1; multiplier shifts right by 1 (logical); counter increments.
REQ-021 Latency: done is high exactly WIDTH+1 cycles after the start-sampling edge; busy is high for exactly WIDTH cycles.
REQ-022 done is high only in DONE.
- Mul_Res and Status_Bits are valid when done=1.
- Mul_Res holds its value until the next start is accepted.
REQ-023 start while BUSY or DONE is ignored; no queueing.
REQ-024 flush in BUSY forces IDLE on the next edge with no done pulse.
REQ-025 flush in DONE suppresses nothing; done still completes.
REQ-026 flush and start together in IDLE: flush wins and start is ignored.
REQ-027 Status_Bits is combinational from Mul_Res; C and V are constant 0.

Reset
REQ-028 While rst=0, all of the following hold:
- State = IDLE.
- busy = 0, done = 0, S_out = 0.
- Mul_Res = 0, Dest_out = 0, Status_Bits = 4'b0100.
- Counter and operand registers = 0.
REQ-029 Reset asserted mid-operation discards the operation immediately; after release the block waits in IDLE for a new start.

Configuration
REQ-030 Macro MUL_ACC_EN:
- Defined: on start with acc_en=1, the accumulator is loaded with Acc instead of 0, so Mul_Res = Val_1*Val_2 + Acc (mod 2^WIDTH).
- Not defined: the Acc and acc_en ports still exist but are ignored, and the accumulator always starts at 0.

Structure
REQ-031 A shared package holds the state enumeration (IDLE/BUSY/DONE), the default WIDTH constant and the status-bit index constants (N=3, Z=2, C=1, V=0).
REQ-032 One sub-module, mul_step, holds the combinational add-and-shift for a single iteration; the FSM, counter and registers stay in exe_mul_sequencer.

Verification
REQ-033 start with Val_1=7, Val_2=6 -> done after 33 cycles; Mul_Res=42; Status_Bits=4'b0000; busy high for 32 cycles.
REQ-034 Val_1=32'hFFFFFFFF, Val_2=2 -> Mul_Res=32'hFFFFFFFE; Status_Bits=4'b1000.
REQ-035 Val_1=0, Val_2=32'h12345678 -> Mul_Res=0; Status_Bits=4'b0100.
REQ-036 flush at BUSY cycle 10 -> no done pulse; busy drops next cycle; a new start then yields the correct product.
REQ-037 rst low at BUSY cycle 5 -> all outputs reach reset values immediately; rst released, then start 3*3 -> Mul_Res=9.
REQ-038 MUL_ACC_EN defined, acc_en=1, 3*4 with Acc=5 -> Mul_Res=17; same stimulus with the macro undefined -> Mul_Res=12.

Source files
------------

// File: rtl/exe_mul_sequencer_pkg.sv
// ============================================================================
// Module      : exe_mul_sequencer_pkg
// Description : Shared types and constants for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_mul_sequencer_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Bit positions within the {N,Z,C,V} status nibble
   localparam int STAT_N = 3;
   localparam int STAT_Z = 2;
   localparam int STAT_C = 1;
   localparam int STAT_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/exe_mul_sequencer_mul_step.sv
// ============================================================================
// Module      : mul_step
// Description : One shift-and-add iteration of the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_step
   import exe_mul_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] mcand_next,
   output logic [WIDTH-1:0] mplier_next
);

   always_comb begin
      acc_next    = mplier[0] ? (acc + mcand) : acc;
      mcand_next  = {mcand[WIDTH-2:0], 1'b0};
      mplier_next = {1'b0, mplier[WIDTH-1:1]};
   end

endmodule

`default_nettype wire

// File: rtl/exe_mul_sequencer.sv
// ============================================================================
// Module      : exe_mul_sequencer
// Description : WIDTH-cycle shift-and-add multiplier with freeze/done handshake.
//               Define MUL_ACC_EN to preload the accumulator with Acc (MLA).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_mul_sequencer
   import exe_mul_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] Val_1,
   input  logic [WIDTH-1:0] Val_2,
   input  logic [WIDTH-1:0] Acc,
   input  logic             acc_en,
   input  logic             S,
   input  logic [3:0]       Dest,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Mul_Res,
   output logic [3:0]       Dest_out,
   output logic             S_out,
   output logic [3:0]       Status_Bits
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [3:0]       dest_r;
   logic             s_r;
   logic [WIDTH-1:0] acc_init;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] mcand_step;
   logic [WIDTH-1:0] mplier_step;
   logic             accept;

`ifdef MUL_ACC_EN
   assign acc_init = acc_en ? Acc : '0;
`else
   logic unused_acc_inputs;
   assign unused_acc_inputs = ^{Acc, acc_en};
   assign acc_init          = '0;
`endif

   // Flush takes priority over a simultaneous start in IDLE
   assign accept = (state == ST_IDLE) && start && !flush;

   mul_step #(
      .WIDTH (WIDTH)
   ) u_mul_step (
      .acc         (acc),
      .mcand       (mcand),
      .mplier      (mplier),
      .acc_next    (acc_step),
      .mcand_next  (mcand_step),
      .mplier_next (mplier_step)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_BUSY;
         ST_BUSY: begin
            if (flush)                 state_next = ST_IDLE;
            else if (cnt == CNT_LAST)  state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_BUSY);
      done = (state == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         dest_r <= '0;
         s_r    <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         acc    <= acc_init;
         mcand  <= Val_1;
         mplier <= Val_2;
         dest_r <= Dest;
         s_r    <= S;
      end else if (state == ST_BUSY && !flush) begin
         cnt    <= cnt + 1'b1;
         acc    <= acc_step;
         mcand  <= mcand_step;
         mplier <= mplier_step;
      end
   end

   // The accumulator is the result; it only changes once a new start is taken
   always_comb begin
      Mul_Res             = acc;
      Dest_out            = dest_r;
      S_out               = s_r & done;
      Status_Bits         = '0;
      Status_Bits[STAT_N] = acc[WIDTH-1];
      Status_Bits[STAT_Z] = (acc == '0);
      Status_Bits[STAT_C] = 1'b0;
      Status_Bits[STAT_V] = 1'b0;
   end

endmodule

`default_nettype wire
